// File: rtl/led_pkg.sv
// Shared types for the frame scheduler: buffer count, buffer index and buffer state.
package led_pkg;

  localparam int NBUF = 3;

  typedef logic [1:0] buf_idx_t;

  typedef enum logic [1:0] {
    FREE    = 2'd0,
    LOADING = 2'd1,
    READY   = 2'd2,
    SHOWING = 2'd3
  } buf_state_t;

endpackage

// File: rtl/first_free.sv
// Combinational priority encoder: index of the lowest-numbered FREE buffer.
module first_free
  import led_pkg::*;
(
  input  logic [NBUF-1:0] free_mask,
  output buf_idx_t        idx,
  output logic            found
);

  // NOTE: every output of an always_comb gets a default first, so no path can infer a latch.
  always_comb begin
    idx   = '0;
    found = 1'b0;
    // Scan from the top down so the lowest FREE index is the last one written.
    for (int i = NBUF - 1; i >= 0; i--) begin
      if (free_mask[i]) begin
        idx   = buf_idx_t'(i);
        found = 1'b1;
      end
    end
  end

endmodule

// File: rtl/frame_scheduler.sv
// Triple-buffer scheduler between a frame loader and a display scanner.
// Optional stale-frame blanking is enabled by defining FRAME_SCHEDULER_STALE_BLANK_EN.
module frame_scheduler
  import led_pkg::*;
#(
  parameter int STALE_LIMIT = 255,
  parameter int CNT_W       = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             ld_req,
  input  logic             ld_done,
  input  logic             sc_req,
  output logic             ld_gnt,
  output logic [1:0]       ld_buf,
  output logic             sc_gnt,
  output logic [1:0]       sc_buf,
  output logic             sc_new,
  output logic [CNT_W-1:0] drop_cnt,
  output logic             proto_err,
  output logic             blank
);

  buf_state_t      state    [NBUF];
  buf_state_t      state_nx [NBUF];
  logic [NBUF-1:0] free_mask;
  buf_idx_t        free_idx, load_idx, ready_idx, show_idx, sc_idx;
  logic            free_found, load_any, ready_any;
  logic            ld_grant, load_done, sc_fresh, drop_inc, err_set;

  first_free u_first_free (
    .free_mask (free_mask),
    .idx       (free_idx),
    .found     (free_found)
  );

  // Decode the current buffer roles from the state array.
  always_comb begin
    free_mask = '0;
    load_any  = 1'b0;
    ready_any = 1'b0;
    load_idx  = '0;
    ready_idx = '0;
    show_idx  = '0;
    for (int i = 0; i < NBUF; i++) begin
      case (state[i])
        FREE:    free_mask[i] = 1'b1;
        LOADING: begin load_any  = 1'b1; load_idx  = buf_idx_t'(i); end
        READY:   begin ready_any = 1'b1; ready_idx = buf_idx_t'(i); end
        SHOWING: show_idx = buf_idx_t'(i);
      endcase
    end
  end

  // All decisions use start-of-cycle states; a completing load is applied before the scan swap.
  always_comb begin
    state_nx  = state;
    ld_grant  = 1'b0;
    load_done = ld_done && load_any;
    drop_inc  = 1'b0;
    err_set   = (ld_done && !load_any) || (sc_req && sc_gnt);
    sc_fresh  = 1'b0;
    sc_idx    = show_idx;

    if (ld_req && !load_any && free_found) begin
      state_nx[free_idx] = LOADING;
      ld_grant           = 1'b1;
    end

    if (load_done) begin
      if (ready_any) begin
        state_nx[ready_idx] = FREE;
        drop_inc            = 1'b1;
      end
      state_nx[load_idx] = READY;
    end

    if (sc_req && (load_done || ready_any)) begin
      sc_fresh           = 1'b1;
      sc_idx             = load_done ? load_idx : ready_idx;
      state_nx[show_idx] = FREE;
      state_nx[sc_idx]   = SHOWING;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      // NOTE: the small state array carries the buffer invariant, so it is reset explicitly.
      state[0] <= SHOWING;
      for (int i = 1; i < NBUF; i++) state[i] <= FREE;
      ld_gnt    <= 1'b0;
      ld_buf    <= '0;
      sc_gnt    <= 1'b0;
      sc_buf    <= '0;
      sc_new    <= 1'b0;
      drop_cnt  <= '0;
      proto_err <= 1'b0;
    end else begin
      state  <= state_nx;
      ld_gnt <= ld_grant;
      sc_gnt <= sc_req;
      if (ld_grant) ld_buf <= free_idx;
      if (sc_req) begin
        sc_buf <= sc_idx;
        sc_new <= sc_fresh;
      end
      if (drop_inc && (drop_cnt != '1)) drop_cnt <= drop_cnt + 1'b1;
      if (err_set) proto_err <= 1'b1;
    end
  end

`ifdef FRAME_SCHEDULER_STALE_BLANK_EN
  localparam int STALE_W = (STALE_LIMIT < 2) ? 1 : $clog2(STALE_LIMIT + 1);
  localparam logic [STALE_W-1:0] STALE_MAX = STALE_W'(STALE_LIMIT);

  logic [STALE_W-1:0] stale_cnt;

  // Counts consecutive repeat grants; blank is registered together with the grant that reaches the limit.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stale_cnt <= '0;
      blank     <= 1'b0;
    end else if (sc_req) begin
      if (sc_fresh) begin
        stale_cnt <= '0;
        blank     <= 1'b0;
      end else if (stale_cnt != STALE_MAX) begin
        stale_cnt <= stale_cnt + 1'b1;
        blank     <= ((stale_cnt + 1'b1) == STALE_MAX);
      end
    end
  end
`else
  assign blank = 1'b0;
`endif

endmodule
